id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline register between decode and execute.
- Captures the decoder's control bundle together with the operand data, and carries them into EX.
- Contains load-use hazard detection. On a hazard it stalls PC and IF/ID and inserts a bubble.
- Honours a flush from branch resolution and a global hold (memory wait).
- Keeps saturating bubble and flush counters for debug.

Parameters:
- N, 32, datapath width (PC, register data, immediate).
- CNT_W, 16, width of the debug counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- hold  in  1  freeze the entire stage (downstream wait)
- flush  in  1  branch taken in EX; kill the instruction entering EX
- id_valid  in  1  ID holds a real instruction
- id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write, id_jsel, id_mux_rf_sel  in  1 each  decoder control bits
- id_alu_op  in  2  decoder ALU class
- id_save_method  in  2  store width (00 byte, 01 half, 10 word)
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  N each  operands
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_funct3  in  3  funct3 field
- id_funct7b5  in  1  instruction bit 30
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1  EX holds a real instruction
- ex_* (one per id_* above)  out  same width as the matching id_*  registered copies
- bubble_cnt  out  CNT_W  load-use bubbles inserted, saturating
- flush_cnt  out  CNT_W  valid instructions flushed, saturating

Behaviour:

Reset:
- rst_n low clears every ex_* output, ex_valid, bubble_cnt and flush_cnt to 0 immediately, without waiting for clk.
- stall is 0 while in reset.
- Reset asserted mid-stall or mid-hold discards the held state.

Hazard detection (combinational):
- use_rs1 = id_mux_rf_sel. AUIPC (mux_rf_sel=0) reads no rs1.
- use_rs2 = !id_alu_src | id_mem_write | id_branch.
- lu = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((use_rs1 & ex_rd == id_rs1) | (use_rs2 & ex_rd == id_rs2)).
- stall = lu & !flush & !hold.

Update at each rising clk, highest priority first:
1. flush=1: load a bubble. A bubble is ex_valid=0 with all control ex_* = 0; data ex_* are don't-care and are loaded with 0. flush_cnt += 1 when id_valid=1.
2. hold=1: all ex_* registers and both counters keep their values. stall=0, because upstream is frozen by the same hold.
3. lu=1: load a bubble. bubble_cnt += 1.
4. Otherwise: every ex_* takes its id_* value and ex_valid = id_valid.
   - id_valid=0: control bits are forced to 0 regardless of the inputs, so that no stray writes occur.

Timing:
- Latency is 1 cycle from ID to EX.
- Each load-use dependency produces exactly one bubble. The following cycle EX holds the bubble, so lu=0 and the stalled instruction advances.
- Counters saturate at all-ones and never wrap.
- Simultaneous flush and lu: flush wins. Only flush_cnt increments and stall=0.

Register x0:
- A destination of x0 never triggers a hazard.

Store width:
- ex_save_method is passed through verbatim.
- This stage does not decode funct3 into store width.

Test Plan:
1. Reset: drive random id_* with rst_n=0, then release -> all ex_*=0, ex_valid=0, both counters 0. Assert rst_n mid-cycle -> outputs clear before the next edge.
2. Pass-through: R-type add, id_pc=0x100, id_rs1_data=5, id_rs2_data=7, rd=3 -> next edge ex_pc=0x100, ex_reg_write=1, ex_alu_op=10, ex_valid=1, stall=0 throughout.
3. Load-use: lw x5 in EX, then add x6,x5,x1 in ID -> stall=1 for one cycle, then a bubble in EX (ex_valid=0, ex_reg_write=0), bubble_cnt=1; the add reaches EX on the following edge. Repeat with rd=x0 -> no stall. Repeat with a dependent AUIPC on rs1=x5 -> no stall.
4. Flush priority: lw x5 in EX, dependent sw in ID, flush=1 in the same cycle -> stall=0, EX gets a bubble, flush_cnt=1, bubble_cnt unchanged.
5. Hold: hold=1 for 3 cycles with changing id_* -> ex_* and counters frozen, stall=0. After release, the stage resumes with the current id_* values.
6. Saturation: with CNT_W=4, force 17 load-use bubbles -> bubble_cnt stays at 15.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection,
// flush/hold handling and saturating debug counters.
module id_ex_stage #(
   parameter int N     = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hold,
   input  logic             flush,
   input  logic             id_valid,
   input  logic             id_branch,
   input  logic             id_mem_read,
   input  logic             id_mem_to_reg,
   input  logic             id_mem_write,
   input  logic             id_alu_src,
   input  logic             id_reg_write,
   input  logic             id_jsel,
   input  logic             id_mux_rf_sel,
   input  logic [1:0]       id_alu_op,
   input  logic [1:0]       id_save_method,
   input  logic [N-1:0]     id_pc,
   input  logic [N-1:0]     id_rs1_data,
   input  logic [N-1:0]     id_rs2_data,
   input  logic [N-1:0]     id_imm,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic [2:0]       id_funct3,
   input  logic             id_funct7b5,
   output logic             stall,
   output logic             ex_valid,
   output logic             ex_branch,
   output logic             ex_mem_read,
   output logic             ex_mem_to_reg,
   output logic             ex_mem_write,
   output logic             ex_alu_src,
   output logic             ex_reg_write,
   output logic             ex_jsel,
   output logic             ex_mux_rf_sel,
   output logic [1:0]       ex_alu_op,
   output logic [1:0]       ex_save_method,
   output logic [N-1:0]     ex_pc,
   output logic [N-1:0]     ex_rs1_data,
   output logic [N-1:0]     ex_rs2_data,
   output logic [N-1:0]     ex_imm,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [4:0]       ex_rd,
   output logic [2:0]       ex_funct3,
   output logic             ex_funct7b5,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   logic w_use_rs1;
   logic w_use_rs2;
   logic w_lu;
   logic w_bubble;
   logic w_load;
   logic w_bub_inc;
   logic w_fl_inc;

   logic [CNT_W-1:0] r_bubble_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   // AUIPC has mux_rf_sel=0 and never reads rs1
   assign w_use_rs1 = id_mux_rf_sel;
   assign w_use_rs2 = !id_alu_src | id_mem_write | id_branch;

   assign w_lu = id_valid & ex_valid & ex_mem_read
               & (ex_rd != 5'd0)
               & ((w_use_rs1 & (ex_rd == id_rs1))
                | (w_use_rs2 & (ex_rd == id_rs2)));

   assign stall     = rst_n & w_lu & !flush & !hold;
   assign w_bubble  = flush | (!hold & w_lu);
   assign w_load    = !flush & !hold & !w_lu;
   assign w_bub_inc = !flush & !hold & w_lu;
   assign w_fl_inc  = flush & id_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid       <= 1'b0;
         ex_branch      <= 1'b0;
         ex_mem_read    <= 1'b0;
         ex_mem_to_reg  <= 1'b0;
         ex_mem_write   <= 1'b0;
         ex_alu_src     <= 1'b0;
         ex_reg_write   <= 1'b0;
         ex_jsel        <= 1'b0;
         ex_mux_rf_sel  <= 1'b0;
         ex_alu_op      <= '0;
         ex_save_method <= '0;
         ex_pc          <= '0;
         ex_rs1_data    <= '0;
         ex_rs2_data    <= '0;
         ex_imm         <= '0;
         ex_rs1         <= '0;
         ex_rs2         <= '0;
         ex_rd          <= '0;
         ex_funct3      <= '0;
         ex_funct7b5    <= 1'b0;
      end else if (w_bubble) begin
         ex_valid       <= 1'b0;
         ex_branch      <= 1'b0;
         ex_mem_read    <= 1'b0;
         ex_mem_to_reg  <= 1'b0;
         ex_mem_write   <= 1'b0;
         ex_alu_src     <= 1'b0;
         ex_reg_write   <= 1'b0;
         ex_jsel        <= 1'b0;
         ex_mux_rf_sel  <= 1'b0;
         ex_alu_op      <= '0;
         ex_save_method <= '0;
         ex_pc          <= '0;
         ex_rs1_data    <= '0;
         ex_rs2_data    <= '0;
         ex_imm         <= '0;
         ex_rs1         <= '0;
         ex_rs2         <= '0;
         ex_rd          <= '0;
         ex_funct3      <= '0;
         ex_funct7b5    <= 1'b0;
      end else if (w_load) begin
         // invalid slots carry data but never any control
         ex_valid       <= id_valid;
         ex_branch      <= id_valid & id_branch;
         ex_mem_read    <= id_valid & id_mem_read;
         ex_mem_to_reg  <= id_valid & id_mem_to_reg;
         ex_mem_write   <= id_valid & id_mem_write;
         ex_alu_src     <= id_valid & id_alu_src;
         ex_reg_write   <= id_valid & id_reg_write;
         ex_jsel        <= id_valid & id_jsel;
         ex_mux_rf_sel  <= id_valid & id_mux_rf_sel;
         ex_alu_op      <= id_valid ? id_alu_op : 2'b00;
         ex_save_method <= id_valid ? id_save_method : 2'b00;
         ex_pc          <= id_pc;
         ex_rs1_data    <= id_rs1_data;
         ex_rs2_data    <= id_rs2_data;
         ex_imm         <= id_imm;
         ex_rs1         <= id_rs1;
         ex_rs2         <= id_rs2;
         ex_rd          <= id_rd;
         ex_funct3      <= id_funct3;
         ex_funct7b5    <= id_funct7b5;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bubble_cnt <= '0;
         r_flush_cnt  <= '0;
      end else begin
         if (w_bub_inc && r_bubble_cnt != '1)
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
         if (w_fl_inc && r_flush_cnt != '1)
            r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign bubble_cnt = r_bubble_cnt;
   assign flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage (CNT_W=4 so
// counter saturation is reachable).
module tb_id_ex_stage;

   localparam int N = 32;
   localparam int CW = 4;

   typedef struct packed {
      logic        valid;
      logic        branch;
      logic        mem_read;
      logic        mem_to_reg;
      logic        mem_write;
      logic        alu_src;
      logic        reg_write;
      logic        jsel;
      logic        mux_rf_sel;
      logic [1:0]  alu_op;
      logic [1:0]  save_method;
      logic [31:0] pc;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic        funct7b5;
   } ins_t;

   typedef struct packed {
      ins_t          ex;
      logic [CW-1:0] b;
      logic [CW-1:0] f;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic hold = 1'b0;
   logic flush = 1'b0;
   ins_t cur = '0;
   ins_t obs;

   logic stall;
   logic ex_valid, ex_branch, ex_mem_read, ex_mem_to_reg;
   logic ex_mem_write, ex_alu_src, ex_reg_write, ex_jsel;
   logic ex_mux_rf_sel;
   logic [1:0] ex_alu_op, ex_save_method;
   logic [N-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0] ex_rs1, ex_rs2, ex_rd;
   logic [2:0] ex_funct3;
   logic ex_funct7b5;
   logic [CW-1:0] bubble_cnt, flush_cnt;

   ins_t m_ex = '0;
   logic [CW-1:0] m_b = '0;
   logic [CW-1:0] m_f = '0;
   exp_t q[$];
   int checks = 0;
   int errs = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.N(N), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
      .id_valid(cur.valid), .id_branch(cur.branch),
      .id_mem_read(cur.mem_read), .id_mem_to_reg(cur.mem_to_reg),
      .id_mem_write(cur.mem_write), .id_alu_src(cur.alu_src),
      .id_reg_write(cur.reg_write), .id_jsel(cur.jsel),
      .id_mux_rf_sel(cur.mux_rf_sel), .id_alu_op(cur.alu_op),
      .id_save_method(cur.save_method), .id_pc(cur.pc),
      .id_rs1_data(cur.rs1_data), .id_rs2_data(cur.rs2_data),
      .id_imm(cur.imm), .id_rs1(cur.rs1), .id_rs2(cur.rs2),
      .id_rd(cur.rd), .id_funct3(cur.funct3),
      .id_funct7b5(cur.funct7b5),
      .stall(stall), .ex_valid(ex_valid), .ex_branch(ex_branch),
      .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
      .ex_reg_write(ex_reg_write), .ex_jsel(ex_jsel),
      .ex_mux_rf_sel(ex_mux_rf_sel), .ex_alu_op(ex_alu_op),
      .ex_save_method(ex_save_method), .ex_pc(ex_pc),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
      .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_funct3(ex_funct3),
      .ex_funct7b5(ex_funct7b5),
      .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
   );

   assign obs = {ex_valid, ex_branch, ex_mem_read, ex_mem_to_reg,
                 ex_mem_write, ex_alu_src, ex_reg_write, ex_jsel,
                 ex_mux_rf_sel, ex_alu_op, ex_save_method, ex_pc,
                 ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
                 ex_rd, ex_funct3, ex_funct7b5};

   task automatic chk(string tag, logic [159:0] got,
                      logic [159:0] want);
      checks++;
      assert (got === want) else begin
         errs++;
         $error("FAIL %s: got=%h want=%h", tag, got, want);
      end
   endtask

   function automatic logic f_lu(ins_t e, ins_t d);
      logic u1, u2;
      u1 = d.mux_rf_sel;
      u2 = !d.alu_src | d.mem_write | d.branch;
      return e.valid & e.mem_read & (e.rd != 5'd0) & d.valid
           & ((u1 & (e.rd == d.rs1)) | (u2 & (e.rd == d.rs2)));
   endfunction

   task automatic cycle(string tag);
      exp_t e;
      logic lu;
      #1;
      lu = f_lu(m_ex, cur);
      chk({tag, ".stall"}, 160'(stall),
          160'(rst_n & lu & !flush & !hold));
      e.ex = m_ex;
      e.b = m_b;
      e.f = m_f;
      if (!rst_n) begin
         e = '0;
      end else if (flush) begin
         e.ex = '0;
         if (cur.valid && m_f != '1) e.f = m_f + 1'b1;
      end else if (hold) begin
         e.ex = m_ex;
      end else if (lu) begin
         e.ex = '0;
         if (m_b != '1) e.b = m_b + 1'b1;
      end else begin
         e.ex = cur;
         if (!cur.valid) begin
            e.ex.branch = 0; e.ex.mem_read = 0;
            e.ex.mem_to_reg = 0; e.ex.mem_write = 0;
            e.ex.alu_src = 0; e.ex.reg_write = 0;
            e.ex.jsel = 0; e.ex.mux_rf_sel = 0;
            e.ex.alu_op = 0; e.ex.save_method = 0;
         end
      end
      q.push_back(e);
      @(posedge clk);
      #1;
      e = q.pop_front();
      m_ex = e.ex;
      m_b = e.b;
      m_f = e.f;
      chk({tag, ".ex"}, 160'(obs), 160'(e.ex));
      chk({tag, ".bcnt"}, 160'(bubble_cnt), 160'(e.b));
      chk({tag, ".fcnt"}, 160'(flush_cnt), 160'(e.f));
   endtask

   function automatic ins_t mk(logic [4:0] rd, rs1, rs2,
                               logic [31:0] pc);
      ins_t r = '0;
      r.valid = 1'b1;
      r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
      r.pc = pc;
      r.rs1_data = pc ^ 32'h0000_5a5a;
      r.rs2_data = pc ^ 32'ha5a5_0000;
      return r;
   endfunction

   function automatic ins_t rtype(logic [4:0] rd, rs1, rs2,
                                  logic [31:0] pc);
      ins_t r = mk(rd, rs1, rs2, pc);
      r.reg_write = 1; r.mux_rf_sel = 1; r.alu_op = 2'b10;
      r.funct7b5 = pc[4];
      return r;
   endfunction

   function automatic ins_t lw(logic [4:0] rd, rs1,
                               logic [31:0] pc);
      ins_t r = mk(rd, rs1, 5'd4, pc);
      r.mem_read = 1; r.mem_to_reg = 1; r.reg_write = 1;
      r.alu_src = 1; r.mux_rf_sel = 1; r.funct3 = 3'b010;
      r.imm = 32'd8;
      return r;
   endfunction

   function automatic ins_t sw(logic [4:0] rs1, rs2,
                               logic [31:0] pc);
      ins_t r = mk(5'd0, rs1, rs2, pc);
      r.mem_write = 1; r.alu_src = 1; r.mux_rf_sel = 1;
      r.save_method = 2'b10; r.funct3 = 3'b010;
      r.imm = 32'd12;
      return r;
   endfunction

   initial begin
      // reset with random inputs
      cur = {$urandom, $urandom, $urandom, $urandom, $urandom};
      hold = 1'b0;
      flush = 1'b0;
      cycle("rst0");
      cur = {$urandom, $urandom, $urandom, $urandom, $urandom};
      cycle("rst1");
      cur = '0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle("idle");

      // pass-through R-type add x3,x1,x2
      cur = rtype(5'd3, 5'd1, 5'd2, 32'h100);
      cur.rs1_data = 32'd5;
      cur.rs2_data = 32'd7;
      cycle("add");
      chk("add.pc", 160'(ex_pc), 160'(32'h100));
      chk("add.aluop", 160'(ex_alu_op), 160'(2'b10));

      // invalid slot: controls must be stripped
      cur = rtype(5'd9, 5'd1, 5'd2, 32'h104);
      cur.valid = 1'b0;
      cycle("inval");

      // load-use on rs2
      cur = lw(5'd5, 5'd2, 32'h108);
      cycle("lw1");
      cur = rtype(5'd6, 5'd1, 5'd5, 32'h10c);
      cycle("lu_bub");
      chk("lu.bcnt1", 160'(bubble_cnt), 160'(1));
      cycle("lu_go");

      // load to x0 never stalls
      cur = lw(5'd0, 5'd2, 32'h110);
      cycle("lw0");
      cur = rtype(5'd6, 5'd0, 5'd0, 32'h114);
      cycle("x0_dep");

      // AUIPC with rs1/rs2 fields = x5
      cur = lw(5'd5, 5'd2, 32'h118);
      cycle("lw2");
      cur = mk(5'd7, 5'd5, 5'd5, 32'h11c);
      cur.reg_write = 1; cur.alu_src = 1; cur.imm = 32'h1000;
      cycle("auipc");

      // load-use on rs1 of a branch
      cur = lw(5'd5, 5'd2, 32'h120);
      cycle("lw3");
      cur = mk(5'd0, 5'd5, 5'd1, 32'h124);
      cur.branch = 1; cur.mux_rf_sel = 1; cur.alu_op = 2'b01;
      cycle("beq_bub");
      cycle("beq_go");

      // flush beats load-use
      cur = lw(5'd5, 5'd2, 32'h128);
      cycle("lw4");
      cur = sw(5'd1, 5'd5, 32'h12c);
      flush = 1'b1;
      cycle("flush_lu");
      chk("flush.fcnt1", 160'(flush_cnt), 160'(1));
      cur.valid = 1'b0;
      cycle("flush_inv");
      flush = 1'b0;
      cur = sw(5'd1, 5'd5, 32'h130);
      cycle("sw_go");

      // hold freezes stage, even with a pending load-use
      cur = lw(5'd5, 5'd2, 32'h134);
      cycle("lw5");
      hold = 1'b1;
      cur = rtype(5'd6, 5'd5, 5'd1, 32'h138);
      cycle("hold0");
      cur = rtype(5'd8, 5'd3, 5'd4, 32'h13c);
      cycle("hold1");
      cur = sw(5'd5, 5'd5, 32'h140);
      cycle("hold2");
      hold = 1'b0;
      cycle("hold_rel");
      cycle("hold_go");

      // bubble counter saturation
      for (int i = 0; i < 17; i++) begin
         cur = lw(5'd5, 5'd2, 32'h200 + 32'(i * 8));
         cycle("sat_lw");
         cur = rtype(5'd6, 5'd5, 5'd1, 32'h204 + 32'(i * 8));
         cycle("sat_bub");
      end
      chk("bcnt_sat", 160'(bubble_cnt), 160'(15));

      // asynchronous reset in the middle of a hold
      cur = lw(5'd5, 5'd2, 32'h300);
      cycle("pre_rst");
      hold = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.ex", 160'(obs), 160'(0));
      chk("arst.bcnt", 160'(bubble_cnt), 160'(0));
      chk("arst.stall", 160'(stall), 160'(0));
      m_ex = '0;
      m_b = '0;
      m_f = '0;
      hold = 1'b0;
      cur = rtype(5'd10, 5'd11, 5'd12, 32'h304);
      @(negedge clk);
      rst_n = 1'b1;
      cycle("post_rst");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
